// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: oData = iData_a - iData_b - iB, one bit per clock, LSB first.
// Optional signed-overflow output oOvf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oData,
  output logic             oData_B
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             oOvf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One full-subtractor cell: returns {borrow_out, diff}.
  function automatic logic [1:0] fsub_bit(input logic a, input logic b, input logic bin);
    logic d;
    logic bo;
    d  = a ^ b ^ bin;
    bo = (~a & b) | (~(a ^ b) & bin);
    return {bo, d};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             data_b_q, data_b_d;
  logic [1:0]       cell_s;
  logic             last_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             ovf_q, ovf_d;
`endif

  // Next-state and datapath logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    data_d   = data_q;
    data_b_d = data_b_q;
`ifdef SERIAL_SUB_OVF_EN
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    ovf_d    = ovf_q;
`endif
    cell_s   = fsub_bit(a_q[0], b_q[0], borrow_q);
    last_s   = (cnt_q == CNT_W'(WIDTH - 1));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (iStart) begin
          state_d  = S_RUN;
          a_d      = iData_a;
          b_d      = iData_b;
          borrow_d = iB;
          res_d    = {WIDTH{1'b0}};
          cnt_d    = {CNT_W{1'b0}};
          busy_d   = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          amsb_d   = iData_a[WIDTH-1];
          bmsb_d   = iData_b[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        // Difference bits enter at the MSB so the word is LSB-aligned after WIDTH shifts.
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        res_d    = {cell_s[0], res_q[WIDTH-1:1]};
        borrow_d = cell_s[1];
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (last_s) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          data_d   = {cell_s[0], res_q[WIDTH-1:1]};
          data_b_d = cell_s[1];
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (amsb_q != bmsb_q) && (cell_s[0] != amsb_q);
`endif
        end else begin
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= S_IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= {WIDTH{1'b0}};
      data_b_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      data_q   <= data_d;
      data_b_q <= data_b_d;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oData   = data_q;
  assign oData_B = data_b_q;
`ifdef SERIAL_SUB_OVF_EN
  assign oOvf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed vectors, latency,
// handshake and mid-run reset checks; oOvf checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  typedef struct packed {
    logic [7:0] d;
    logic       b;
    logic       o;
  } exp_t;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iStart = 1'b0;
  logic [7:0] iData_a = 8'h00;
  logic [7:0] iData_b = 8'h00;
  logic       iB = 1'b0;
  logic       oBusy, oDone, oData_B;
  logic [7:0] oData;
`ifdef SERIAL_SUB_OVF_EN
  logic       oOvf;
`endif

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  serial_subtractor #(.WIDTH(8), .CNT_W(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart),
    .iData_a(iData_a), .iData_b(iData_b), .iB(iB),
    .oBusy(oBusy), .oDone(oDone), .oData(oData), .oData_B(oData_B)
`ifdef SERIAL_SUB_OVF_EN
    , .oOvf(oOvf)
`endif
  );

  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every oDone pulse against the oldest expected result.
  always @(negedge iClk) begin
    if (iRst_n && oDone) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("oData", {24'd0, oData}, {24'd0, e.d});
        check("oData_B", {31'd0, oData_B}, {31'd0, e.b});
`ifdef SERIAL_SUB_OVF_EN
        check("oOvf", {31'd0, oOvf}, {31'd0, e.o});
`endif
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic b, input logic o);
    exp_t e;
    e.d = d; e.b = b; e.o = o;
    exp_q.push_back(e);
  endtask

  // Issue one op; optional poke cycle drives a stray iStart mid-run. Checks latency and busy count.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input logic [7:0] prev_d, input int poke);
    int cyc;
    int busy_cnt;
    push(ed, eb, eo);
    @(negedge iClk);
    iData_a = a; iData_b = b; iB = bi; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    cyc = 1; busy_cnt = 0;
    while (!oDone && cyc < 20) begin
      if (oBusy) busy_cnt++;
      if (cyc == 4) check("oData_stable_in_run", {24'd0, oData}, {24'd0, prev_d});
      if (cyc == poke) begin
        iData_a = 8'hAA; iData_b = 8'h11; iB = 1'b1; iStart = 1'b1;
      end else begin
        iStart = 1'b0;
        iData_a = 8'h5A; iData_b = 8'hA5; iB = 1'b1;
      end
      @(negedge iClk);
      cyc++;
    end
    iStart = 1'b0;
    check("start_to_done_cycles", cyc, 9);
    check("busy_cycles", busy_cnt, 8);
  endtask

  initial begin
    int cyc;
    int gap;
    int dones;
    repeat (3) @(negedge iClk);
    check("rst_oBusy", {31'd0, oBusy}, 32'd0);
    check("rst_oDone", {31'd0, oDone}, 32'd0);
    check("rst_oData", {24'd0, oData}, 32'd0);
    check("rst_oData_B", {31'd0, oData_B}, 32'd0);
    iRst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 0);
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h02, 0);
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 8'hFF, 0);
    run_op(8'h78, 8'h78, 1'b1, 8'hFF, 1'b1, 1'b0, 8'hFF, 0);
    run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 0);
    run_op(8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 1'b0, 8'h00, 0);
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 8'hEF, 0);
    run_op(8'h41, 8'h01, 1'b0, 8'h40, 1'b0, 1'b0, 8'h7F, 0);
    // Stray start during RUN must be ignored.
    run_op(8'h3C, 8'h0F, 1'b0, 8'h2D, 1'b0, 1'b0, 8'h40, 3);

    // Back-to-back: hold iStart in the DONE cycle of the previous op.
    push(8'h2D, 1'b0, 1'b0);
    push(8'hFF, 1'b1, 1'b0);
    iData_a = 8'h3C; iData_b = 8'h0F; iB = 1'b0; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    cyc = 1;
    while (!oDone && cyc < 20) begin @(negedge iClk); cyc++; end
    check("b2b_first_latency", cyc, 9);
    iData_a = 8'h01; iData_b = 8'h02; iB = 1'b0; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    gap = 1;
    while (!oDone && gap < 20) begin @(negedge iClk); gap++; end
    check("b2b_done_gap", gap, 9);
    @(negedge iClk);

    // Reset at RUN cycle 4: outputs clear immediately and no oDone follows.
    iData_a = 8'h77; iData_b = 8'h11; iB = 1'b0; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    repeat (3) @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    check("midrst_oBusy", {31'd0, oBusy}, 32'd0);
    check("midrst_oData", {24'd0, oData}, 32'd0);
    check("midrst_oData_B", {31'd0, oData_B}, 32'd0);
    @(negedge iClk);
    iRst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge iClk);
      if (oDone) dones++;
    end
    check("no_done_after_abort", dones, 0);
    run_op(8'hC1, 8'h41, 1'b0, 8'h80, 1'b0, 1'b0, 8'h00, 0);

    repeat (3) @(negedge iClk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
